// File: rtl/knn_result_collector_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | knn_result_collector_if : issue/result/list bus of the k-NN collector |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface knn_result_collector_if #(
    parameter int K    = 4,
    parameter int ID_W = 16
);
    localparam int CW = $clog2(K + 1);

    logic                 start_in;
    logic                 issue_valid_in;
    logic [ID_W-1:0]      issue_id_in;
    logic                 issue_last_in;
    logic                 issue_ready_out;
    logic                 dist_valid_in;
    logic [31:0]          dist_sq_in;
    logic [K*ID_W-1:0]    result_ids_out;
    logic [K*32-1:0]      result_dists_out;
    logic [CW-1:0]        result_count_out;
    logic                 done_out;
    logic                 error_out;

    modport slave (
        input  start_in, issue_valid_in, issue_id_in, issue_last_in,
               dist_valid_in, dist_sq_in,
        output issue_ready_out, result_ids_out, result_dists_out,
               result_count_out, done_out, error_out
    );

    modport master (
        output start_in, issue_valid_in, issue_id_in, issue_last_in,
               dist_valid_in, dist_sq_in,
        input  issue_ready_out, result_ids_out, result_dists_out,
               result_count_out, done_out, error_out
    );
endinterface
`default_nettype wire

// File: rtl/knn_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | knn_result_collector : tags distance results with vertex IDs and     |
// | keeps a sorted K-nearest list. Option: KNN_COLLECT_DEDUP_EN.         |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module knn_result_collector #(
    parameter int K          = 4,
    parameter int ID_W       = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  wire                   clk_in,
    input  wire                   rst_in,
    knn_result_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(K + 1);
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(K);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             w_collect, w_done;

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ID_W:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    w_wr_addr;
    logic             ready_q, ready_d, error_q, error_d;
    logic             w_full, w_empty;
    logic             w_push_req, w_push, w_overflow;
    logic             w_pop_req, w_pop, w_underflow;

    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [31:0]      s1_dist_q, s1_dist_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;

    logic [ID_W-1:0]  slot_ids_q [K];
    logic [ID_W-1:0]  slot_ids_d [K];
    logic [31:0]      slot_dists_q [K];
    logic [31:0]      slot_dists_d [K];
    logic [ID_W-1:0]  w_prev_ids [K];
    logic [31:0]      w_prev_dists [K];
    logic [CW-1:0]    count_q, count_d;
    logic [K-1:0]     w_lt, w_take_new, w_shift;
    logic             w_dup, w_insert;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.start_in) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_COLLECT: if (s1_valid_q && s1_last_q) state_d = S_DONE;
                S_DONE:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_collect = (state_q == S_COLLECT);
        w_done    = (state_q == S_DONE);
    end

    // Full/empty judged on pre-pop pointers, so same-cycle push and pop see the old occupancy
    assign w_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_push_req  = bus.issue_valid_in && (bus.start_in || w_collect);
    assign w_push      = w_push_req && (bus.start_in || !w_full);
    assign w_overflow  = w_push_req && !bus.start_in && w_full;
    assign w_pop_req   = bus.dist_valid_in && !bus.start_in;
    assign w_pop       = w_pop_req && !w_empty;
    assign w_underflow = w_pop_req && w_empty;
    assign w_wr_addr   = bus.start_in ? '0 : wr_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = bus.start_in ? '0 : wr_ptr_q;
        rd_ptr_d = bus.start_in ? '0 : rd_ptr_q;
        if (w_push) wr_ptr_d = wr_ptr_d + PTR_ONE;
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
        error_d = bus.start_in ? 1'b0 : (error_q || w_overflow || w_underflow);
    end

    always_ff @(posedge clk_in) begin
        if (w_push) fifo_mem_q[w_wr_addr] <= {bus.issue_id_in, bus.issue_last_in};
    end

    always_comb begin
        s1_valid_d             = w_pop;
        {s1_id_d, s1_last_d}   = fifo_mem_q[rd_ptr_q[AW-1:0]];
        s1_dist_d              = bus.dist_sq_in;
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_slot
        // Empty slots behave as +infinity, so the first empty slot always accepts
        assign w_lt[gi] = (CW'(gi) >= count_q) || (s1_dist_q < slot_dists_q[gi]);
        if (gi == 0) begin : g_head
            assign w_take_new[gi]   = w_lt[gi];
            assign w_shift[gi]      = 1'b0;
            assign w_prev_ids[gi]   = '0;
            assign w_prev_dists[gi] = '0;
        end else begin : g_body
            assign w_take_new[gi]   = w_lt[gi] && !w_lt[gi-1];
            assign w_shift[gi]      = w_lt[gi-1];
            assign w_prev_ids[gi]   = slot_ids_q[gi-1];
            assign w_prev_dists[gi] = slot_dists_q[gi-1];
        end
        assign bus.result_ids_out[gi*ID_W +: ID_W] = slot_ids_q[gi];
        assign bus.result_dists_out[gi*32 +: 32]   = slot_dists_q[gi];
    end

`ifdef KNN_COLLECT_DEDUP_EN
    logic [K-1:0] w_match;
    for (genvar gj = 0; gj < K; gj++) begin : g_dedup
        assign w_match[gj] = (CW'(gj) < count_q) && (slot_ids_q[gj] == s1_id_q);
    end
    assign w_dup = |w_match;
`else
    assign w_dup = 1'b0;
`endif

    // The last slot losing its compare means the entry is beyond every kept candidate
    assign w_insert = s1_valid_q && w_collect && !bus.start_in && !w_dup && w_lt[K-1];

    always_comb begin
        for (int i = 0; i < K; i++) begin
            slot_ids_d[i]   = slot_ids_q[i];
            slot_dists_d[i] = slot_dists_q[i];
        end
        count_d = count_q;
        if (bus.start_in) begin
            for (int i = 0; i < K; i++) begin
                slot_ids_d[i]   = '0;
                slot_dists_d[i] = '0;
            end
            count_d = '0;
        end else if (w_insert) begin
            for (int i = 0; i < K; i++) begin
                if (w_take_new[i]) begin
                    slot_ids_d[i]   = s1_id_q;
                    slot_dists_d[i] = s1_dist_q;
                end else if (w_shift[i]) begin
                    slot_ids_d[i]   = w_prev_ids[i];
                    slot_dists_d[i] = w_prev_dists[i];
                end
            end
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_dist_q  <= '0;
            s1_id_q    <= '0;
            count_q    <= '0;
            for (int i = 0; i < K; i++) begin
                slot_ids_q[i]   <= '0;
                slot_dists_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_dist_q    <= s1_dist_d;
            s1_id_q      <= s1_id_d;
            count_q      <= count_d;
            slot_ids_q   <= slot_ids_d;
            slot_dists_q <= slot_dists_d;
        end
    end

    assign bus.issue_ready_out  = ready_q;
    assign bus.error_out        = error_q;
    assign bus.done_out         = w_done;
    assign bus.result_count_out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_knn_result_collector : directed bench with a queue-based model    |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_knn_result_collector;
    localparam int K     = 4;
    localparam int ID_W  = 16;
    localparam int DEPTH = 16;
    localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    knn_result_collector_if #(.K(K), .ID_W(ID_W)) bus ();

    knn_result_collector #(.K(K), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    typedef struct packed { logic [31:0] d; logic [15:0] id; } cand_t;
    typedef struct packed { logic [15:0] id; logic last; } tag_t;

    cand_t       m_list[$];
    tag_t        m_tags[$];
    logic        m_err = 1'b0, m_done = 1'b0, m_ready = 1'b0;
    logic        m_pend_v = 1'b0, m_pend_last = 1'b0;
    logic [31:0] m_pend_d = '0;
    logic [15:0] m_pend_id = '0;
    int          m_phase = P_IDLE;
    int          pre_size, pre_phase;
    int          n_chk = 0, n_pass = 0, n_done = 0, d0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_insert(input logic [31:0] d, input logic [15:0] id);
        int    p;
        cand_t c;
`ifdef KNN_COLLECT_DEDUP_EN
        foreach (m_list[j]) if (m_list[j].id == id) return;
`endif
        p = m_list.size();
        for (int j = 0; j < m_list.size(); j++) begin
            if (d < m_list[j].d) begin
                p = j;
                break;
            end
        end
        if (p < K) begin
            c.d  = d;
            c.id = id;
            m_list.insert(p, c);
            if (m_list.size() > K) void'(m_list.pop_back());
        end
    endfunction

    function automatic logic [K*ID_W-1:0] exp_ids();
        logic [K*ID_W-1:0] r = '0;
        for (int i = 0; i < m_list.size(); i++) r[i*ID_W +: ID_W] = m_list[i].id;
        return r;
    endfunction

    function automatic logic [K*32-1:0] exp_dists();
        logic [K*32-1:0] r = '0;
        for (int i = 0; i < m_list.size(); i++) r[i*32 +: 32] = m_list[i].d;
        return r;
    endfunction

    // Reference model: one step per rising edge, asynchronous clear on reset
    initial forever begin
        tag_t t;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_tags.delete();
            m_list.delete();
            m_err = 1'b0; m_done = 1'b0; m_ready = 1'b0; m_pend_v = 1'b0;
            m_phase = P_IDLE;
        end else begin
            pre_size  = m_tags.size();
            pre_phase = m_phase;
            m_done    = 1'b0;
            if (pre_phase == P_DONE) m_phase = P_IDLE;
            if (m_pend_v && pre_phase == P_COLLECT) begin
                model_insert(m_pend_d, m_pend_id);
                if (m_pend_last) begin
                    m_phase = P_DONE;
                    m_done  = 1'b1;
                end
            end
            m_pend_v = 1'b0;
            if (bus.start_in) begin
                m_tags.delete();
                m_list.delete();
                m_err   = 1'b0;
                m_done  = 1'b0;
                m_phase = P_COLLECT;
                if (bus.issue_valid_in) begin
                    t.id = bus.issue_id_in; t.last = bus.issue_last_in;
                    m_tags.push_back(t);
                end
            end else begin
                if (bus.dist_valid_in) begin
                    if (pre_size == 0) m_err = 1'b1;
                    else begin
                        t           = m_tags.pop_front();
                        m_pend_v    = 1'b1;
                        m_pend_d    = bus.dist_sq_in;
                        m_pend_id   = t.id;
                        m_pend_last = t.last;
                    end
                end
                if (bus.issue_valid_in && pre_phase == P_COLLECT) begin
                    if (pre_size >= DEPTH) m_err = 1'b1;
                    else begin
                        t.id = bus.issue_id_in; t.last = bus.issue_last_in;
                        m_tags.push_back(t);
                    end
                end
            end
            m_ready = (m_tags.size() < DEPTH);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ids",   128'(bus.result_ids_out),   128'(exp_ids()));
        chk("dists", 128'(bus.result_dists_out), 128'(exp_dists()));
        chk("count", 128'(bus.result_count_out), 128'(m_list.size()));
        chk("done",  128'(bus.done_out),         128'(m_done));
        chk("error", 128'(bus.error_out),        128'(m_err));
        chk("ready", 128'(bus.issue_ready_out),  128'(m_ready));
        if (bus.done_out) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_q();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    task automatic issue(input logic [15:0] id, input logic last);
        bus.issue_valid_in = 1'b1;
        bus.issue_id_in    = id;
        bus.issue_last_in  = last;
        tick();
        bus.issue_valid_in = 1'b0;
        bus.issue_last_in  = 1'b0;
    endtask

    task automatic result(input logic [31:0] d);
        bus.dist_valid_in = 1'b1;
        bus.dist_sq_in    = d;
        tick();
        bus.dist_valid_in = 1'b0;
    endtask

    initial begin
        bus.start_in = 1'b0; bus.issue_valid_in = 1'b0; bus.issue_id_in = '0;
        bus.issue_last_in = 1'b0; bus.dist_valid_in = 1'b0; bus.dist_sq_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ids",   128'(bus.result_ids_out),   128'(0));
        chk("rst_count", 128'(bus.result_count_out), 128'(0));
        chk("rst_ready", 128'(bus.issue_ready_out),  128'(0));
        rst_n = 1'b1;
        tick();

        // Ordering
        start_q();
        for (int i = 0; i < 5; i++) issue(16'(10 + i), (i == 4));
        d0 = n_done;
        result(32'h40400000); result(32'h3F800000); result(32'h40800000);
        result(32'h3F000000); result(32'h40000000);
        repeat (4) tick();
        chk("order_ids",   128'(bus.result_ids_out), 128'({16'd10, 16'd14, 16'd11, 16'd13}));
        chk("order_dists", 128'(bus.result_dists_out),
            128'({32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000}));
        chk("order_count", 128'(bus.result_count_out), 128'(4));
        chk("order_done",  128'(n_done - d0), 128'(1));
        chk("order_err",   128'(bus.error_out), 128'(0));

        // Tie
        start_q();
        issue(16'd1, 1'b0); issue(16'd2, 1'b1);
        result(32'h3F800000); result(32'h3F800000);
        repeat (4) tick();
        chk("tie_ids",   128'(bus.result_ids_out[31:0]), 128'({16'd2, 16'd1}));
        chk("tie_count", 128'(bus.result_count_out), 128'(2));

        // Underflow
        start_q();
        result(32'h40000000);
        repeat (2) tick();
        chk("uflow_err",   128'(bus.error_out), 128'(1));
        chk("uflow_count", 128'(bus.result_count_out), 128'(0));

        // Overflow
        start_q();
        chk("oflow_clr", 128'(bus.error_out), 128'(0));
        for (int i = 0; i < DEPTH; i++) issue(16'(100 + i), 1'b0);
        chk("oflow_ready", 128'(bus.issue_ready_out), 128'(0));
        chk("oflow_err0",  128'(bus.error_out), 128'(0));
        issue(16'd200, 1'b0);
        tick();
        chk("oflow_err1",  128'(bus.error_out), 128'(1));

        // Restart mid-query, then a query with push/pop overlap
        start_q();
        issue(16'd20, 1'b0); issue(16'd21, 1'b0); issue(16'd22, 1'b1);
        d0 = n_done;
        result(32'h40A00000); result(32'h40C00000);
        start_q();
        chk("rs_count", 128'(bus.result_count_out), 128'(0));
        bus.start_in = 1'b1; bus.issue_valid_in = 1'b1; bus.issue_id_in = 16'd30;
        tick();
        bus.start_in = 1'b0; bus.issue_id_in = 16'd31; bus.issue_last_in = 1'b1;
        bus.dist_valid_in = 1'b1; bus.dist_sq_in = 32'h40000000;
        tick();
        bus.issue_valid_in = 1'b0; bus.issue_last_in = 1'b0; bus.dist_sq_in = 32'h3F800000;
        tick();
        bus.dist_valid_in = 1'b0;
        repeat (4) tick();
        chk("rs_ids",   128'(bus.result_ids_out[31:0]), 128'({16'd30, 16'd31}));
        chk("rs_count2", 128'(bus.result_count_out), 128'(2));
        chk("rs_done",  128'(n_done - d0), 128'(1));

        // Duplicate IDs
        start_q();
        issue(16'd7, 1'b0); issue(16'd7, 1'b1);
        result(32'h40000000); result(32'h3F800000);
        repeat (4) tick();
`ifdef KNN_COLLECT_DEDUP_EN
        chk("dup_count", 128'(bus.result_count_out), 128'(1));
        chk("dup_slot",  128'({bus.result_ids_out[15:0], bus.result_dists_out[31:0]}),
            128'({16'd7, 32'h40000000}));
`else
        chk("dup_count", 128'(bus.result_count_out), 128'(2));
        chk("dup_slot",  128'({bus.result_ids_out[31:0], bus.result_dists_out[63:0]}),
            128'({16'd7, 16'd7, 32'h40000000, 32'h3F800000}));
`endif

        // Asynchronous reset during back-to-back results
        start_q();
        for (int i = 0; i < 4; i++) issue(16'(40 + i), (i == 3));
        result(32'h40400000); result(32'h3F800000);
        bus.dist_valid_in = 1'b1; bus.dist_sq_in = 32'h40000000;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ids",   128'(bus.result_ids_out),   128'(0));
        chk("ar_dists", 128'(bus.result_dists_out), 128'(0));
        chk("ar_misc",  128'({bus.result_count_out, bus.done_out, bus.error_out, bus.issue_ready_out}),
            128'(0));
        bus.dist_valid_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_q();
        d0 = n_done;
        issue(16'd50, 1'b1);
        result(32'h40000000);
        repeat (4) tick();
        chk("ar_recover", 128'({bus.result_ids_out[15:0], bus.result_count_out}), 128'({16'd50, 3'd1}));
        chk("ar_done",    128'(n_done - d0), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
